// File: rtl/tdm_mux_seq.sv
// Registered N-channel time-division multiplexer with manual select and auto round-robin scan.
// Auto mode dwells DWELL enabled cycles per channel and pulses frame on the N-1 -> 0 wrap.
module tdm_mux_seq #(
  parameter int W     = 1,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  j,
  output logic [W-1:0]    g,
  output logic [SELW-1:0] ch,
  output logic            frame
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_LAST  = SELW'(N - 1);
  localparam logic [SELW:0]   NCH      = (SELW+1)'(N);

  logic [N-1:0][W-1:0] jv;
  logic [CNTW-1:0]     cnt, cnt_nx;
  logic [SELW-1:0]     ch_nx;
  logic                wrap;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign jv[k] = j[k*W +: W];
  end

  always_comb begin
    ch_nx  = ch;
    cnt_nx = cnt;
    wrap   = 1'b0;
    if (!mode) begin
      cnt_nx = '0;
      // out-of-range selects (non power-of-2 N) keep the current channel
      if ({1'b0, sel} < NCH) ch_nx = sel;
    end else if (cnt == CNT_LAST) begin
      cnt_nx = '0;
      if (ch == CH_LAST) begin
        ch_nx = '0;
        wrap  = 1'b1;
      end else begin
        ch_nx = ch + 1'b1;
      end
    end else begin
      cnt_nx = cnt + 1'b1;
    end
  end

  // g is sampled from ch_nx so data and channel index always agree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g     <= '0;
      ch    <= '0;
      cnt   <= '0;
      frame <= 1'b0;
    end else if (en) begin
      g     <= jv[ch_nx];
      ch    <= ch_nx;
      cnt   <= cnt_nx;
      frame <= wrap;
    end else begin
      frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_mux_seq.sv
// Bench for tdm_mux_seq: a 4-channel 1-bit instance and a 3-channel 4-bit DWELL=1 instance,
// both compared every cycle against an integer channel/dwell model.
module tb_tdm_mux_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode;
  logic [1:0]  sel;
  logic [3:0]  aj;
  logic [11:0] bj;
  logic [0:0]  a_g;
  logic [1:0]  a_ch, b_ch;
  logic        a_fr, b_fr;
  logic [3:0]  b_g;

  int checks = 0;
  int errors = 0;

  // model state: current channel, dwell position, held output, frame
  int ach = 0, acnt = 0, ag = 0, afr = 0;
  int bch = 0, bcnt = 0, bg = 0, bfr = 0;

  always #5 clk = ~clk;

  tdm_mux_seq #(.W(1), .N(4), .SELW(2), .DWELL(4)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .j(aj),
    .g(a_g), .ch(a_ch), .frame(a_fr));

  tdm_mux_seq #(.W(4), .N(3), .SELW(2), .DWELL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .j(bj),
    .g(b_g), .ch(b_ch), .frame(b_fr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One channel step: manual jumps to any valid sel, auto counts dwell and wraps modulo n.
  task automatic mstep(input int n, input int d, input bit e, input bit m, input int s,
                       input int c, input int k, output int nc, output int nk, output int fr);
    nc = c; nk = k; fr = 0;
    if (e) begin
      if (!m) begin
        nk = 0;
        if (s < n) nc = s;
      end else if (k + 1 >= d) begin
        nk = 0;
        nc = (c + 1) % n;
        fr = (nc == 0) ? 1 : 0;
      end else begin
        nk = k + 1;
      end
    end
  endtask

  task automatic cyc();
    int nca, nka, ncb, nkb;
    mstep(4, 4, en, mode, int'(sel), ach, acnt, nca, nka, afr);
    mstep(3, 1, en, mode, int'(sel), bch, bcnt, ncb, nkb, bfr);
    if (en) begin
      ag = int'((aj >> nca) & 4'h1);
      bg = int'((bj >> (4 * ncb)) & 12'hF);
    end
    ach = nca; acnt = nka; bch = ncb; bcnt = nkb;
    @(posedge clk); #1;
    chk("a_g", 32'(a_g), 32'(ag));
    chk("a_ch", 32'(a_ch), 32'(ach));
    chk("a_frame", 32'(a_fr), 32'(afr));
    chk("b_g", 32'(b_g), 32'(bg));
    chk("b_ch", 32'(b_ch), 32'(bch));
    chk("b_frame", 32'(b_fr), 32'(bfr));
  endtask

  task automatic model_reset();
    ach = 0; acnt = 0; ag = 0; afr = 0;
    bch = 0; bcnt = 0; bg = 0; bfr = 0;
  endtask

  initial begin
    int nfr;
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 2'd0;
    aj = 4'b1110; bj = 12'hCBA;

    // reset held with clock running
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_a_g", 32'(a_g), 32'd0);
      chk("rst_a_ch", 32'(a_ch), 32'd0);
      chk("rst_a_frame", 32'(a_fr), 32'd0);
      chk("rst_b_g", 32'(b_g), 32'd0);
    end
    #3 rst_n = 1'b1;

    // auto scan from release: exactly one frame in 20 cycles
    nfr = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (a_fr) nfr++;
    end
    chk("a_frame_count", 32'(nfr), 32'd1);

    // reach ch=2 cnt=1, then manual sel=0, then back to auto
    repeat (5) cyc();
    mode = 1'b0; sel = 2'd0;
    cyc();
    mode = 1'b1;
    repeat (6) cyc();

    // enable gating mid-dwell
    en = 1'b0;
    repeat (3) cyc();
    en = 1'b1;
    repeat (4) cyc();

    // manual sweep, each select held two cycles
    mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      repeat (2) cyc();
    end
    // out-of-range select on the 3-channel instance holds ch=1
    sel = 2'd1; cyc();
    sel = 2'd3; repeat (2) cyc();

    // async reset asserted between edges
    sel = 2'd1; cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_a_g", 32'(a_g), 32'd0);
    chk("async_a_ch", 32'(a_ch), 32'd0);
    chk("async_b_g", 32'(b_g), 32'd0);
    chk("async_b_ch", 32'(b_ch), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // randomized run with sticky mode and occasional enable drops
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) mode = ~mode;
      en  = ($urandom_range(5) != 0);
      if ($urandom_range(3) == 0) sel = 2'($urandom_range(3));
      aj  = 4'($urandom);
      bj  = 12'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_mux_seq.md
Name: tdm_mux_seq

Overview:
Parametrised, registered N-channel time-division multiplexer. It is the sequential successor to the lab 4:1 mux.
- Manual mode: the external select picks the channel, with output registered.
- Auto mode: an internal dwell counter scans all channels round-robin and flags each completed frame.
- Sits between packed multi-channel data sources and a single-lane consumer (display, serial shifter).

Parameters:
W, 1, data width of each channel in bits
N, 4, number of channels (2..16)
SELW, 2, select/channel-index width; must equal ceil(log2(N))
DWELL, 4, cycles spent on each channel in auto mode (>=1)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
en  input  1  clock enable; when 0 all state holds
mode  input  1  0 = manual select, 1 = auto scan
sel  input  SELW  manual channel select (ignored when mode=1)
j  input  N*W  packed channel data; channel k occupies j[k*W +: W]
g  output  W  registered selected channel data
ch  output  SELW  index of channel currently driven on g
frame  output  1  one-cycle pulse when auto scan wraps N-1 -> 0

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Assertion immediately forces g=0, ch=0, frame=0 and dwell counter cnt=0, regardless of clk. Release takes effect at the next rising edge.
- All outputs are registered. No combinational path exists from inputs to outputs.
- Definitions:
  - ch_next = the channel index ch takes at this edge.
  - Every enabled edge: g <= j[ch_next*W +: W]. g and ch therefore always agree in the same cycle.
  - Latency input -> g is 1 cycle.
- en=0: g, ch and cnt hold; frame <= 0.
- Manual (mode=0, en=1):
  - If sel < N: ch_next = sel.
  - If sel >= N (only possible when N is not a power of 2): ch_next = ch, so g re-samples the held channel.
  - cnt <= 0; frame <= 0.
- Auto (mode=1, en=1):
  - If cnt < DWELL-1: cnt <= cnt+1; ch_next = ch.
  - If cnt == DWELL-1: cnt <= 0; ch_next = (ch == N-1) ? 0 : ch+1.
  - frame <= 1 only on the edge where ch goes N-1 -> 0; otherwise frame <= 0.
  - DWELL=1: ch advances every enabled cycle and frame pulses every N cycles.
  - g tracks live changes on j for the current channel every cycle. Data is not latched once per dwell.
- Mode switches:
  - 0 -> 1: scan starts from the current ch with cnt=0, so the first channel dwells a full DWELL cycles.
  - 1 -> 0: cnt cleared; ch follows sel from that same edge.
- Simultaneous mode toggle and en=0: en wins; nothing changes until en=1.
- Reset mid-scan: scan restarts at ch=0, cnt=0 after release. No frame pulse is produced by reset.
- cnt width is ceil(log2(DWELL)), minimum 1 bit. There is no overflow path, because the counter compares to DWELL-1 exactly.

Test Plan:
1. Reset: hold rst_n=0 with j=4'b1110, mode=1, clk running -> g=0, ch=0, frame=0 throughout. Drop rst_n asynchronously mid-cycle -> outputs clear without waiting for a clk edge.
2. Manual (W=1, N=4): j=4'b1110, sel=0,1,2,3 each held 2 cycles -> one cycle after each sel change: g=0,1,1,1 and ch=0,1,2,3; frame stays 0.
3. Auto (DWELL=4): j=4'b1110, mode=1 for 20 cycles -> ch steps 0,1,2,3 every 4 cycles with g=0,1,1,1. frame=1 for exactly one cycle when ch returns to 0 (cycle 17 after release).
4. Enable gating: in auto mode, drop en for 3 cycles at cnt=2 -> ch, g and cnt frozen. The channel change occurs 2 enabled cycles after en returns.
5. Mode switch: auto at ch=2, cnt=1, switch to mode=0 with sel=0 -> next cycle ch=0, g=j[0]. Switch back to mode=1 -> ch=0 dwells 4 cycles before advancing.
6. Non-power-of-2 (N=3, SELW=2, W=4, DWELL=1): j=12'hCBA, auto -> g=A,B,C,A..., frame every 3rd cycle. Manual sel=3 while ch=1 -> ch stays 1, g=B.
